regfile_scoreboard: RTL and testbench

- Parametrised register file: two combinational read ports, one clocked write-back port, a per-register pending (scoreboard) bit, and same-cycle write-back forwarding.
- Successor to the fixed 16x16 register file. Adds width/depth parameters, a hardwired zero register, hazard tracking for a pipelined datapath, WAW stall generation, and a sticky protocol-error flag.
- Sits between decode/issue (read + issue) and write-back.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard_bits.sv | 61 ++++++
 rtl/regfile_scoreboard.sv | 76 +++++++
 tb/tb_regfile_scoreboard.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int ZERO_ADDR          = 0;

  // busy_count must be able to hold 2**addr_width, hence one extra bit.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Pending-bit scoreboard: per-register hazard bits, WAW stall, busy count and
// the sticky write-back protocol error.
module regfile_scoreboard_bits
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                issue_valid,
  input  logic [ADDR_WIDTH-1:0]               issue_rd,
  input  logic                                wb_valid,
  input  logic [ADDR_WIDTH-1:0]               wb_rd,
  output logic [(1<<ADDR_WIDTH)-1:0]          pending,
  output logic                                issue_stall,
  output logic [count_width(ADDR_WIDTH)-1:0]  busy_count,
  output logic                                wb_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = count_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ZA = ADDR_WIDTH'(ZERO_ADDR);

  logic [DEPTH-1:0] pending_next;
  logic [CW-1:0]    count_next;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == ZA);
  endfunction

  always_comb begin
    issue_stall = issue_valid && pending[issue_rd] &&
                  !(wb_valid && (wb_rd == issue_rd)) && !is_zero(issue_rd);
    pending_next = pending;
    count_next   = '0;
    // A new producer supersedes the completing one, so set beats clear.
    for (int r = 0; r < DEPTH; r++) begin
      if (issue_valid && !issue_stall && (issue_rd == ADDR_WIDTH'(r)) &&
          !is_zero(ADDR_WIDTH'(r)))
        pending_next[r] = 1'b1;
      else if (wb_valid && (wb_rd == ADDR_WIDTH'(r)))
        pending_next[r] = 1'b0;
      count_next = count_next + CW'(pending_next[r]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      busy_count <= '0;
      wb_error   <= 1'b0;
    end else begin
      pending    <= pending_next;
      busy_count <= count_next;
      if (wb_valid && !pending[wb_rd] && !is_zero(wb_rd))
        wb_error <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two combinational read ports, a clocked
// write-back port, same-cycle forwarding and a pending-bit scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [ADDR_WIDTH-1:0]              rs,
  input  logic [ADDR_WIDTH-1:0]              rt,
  output logic [DATA_WIDTH-1:0]              output1,
  output logic [DATA_WIDTH-1:0]              output2,
  output logic                               output1_ready,
  output logic                               output2_ready,
  input  logic                               issue_valid,
  input  logic [ADDR_WIDTH-1:0]              issue_rd,
  output logic                               issue_stall,
  input  logic                               wb_valid,
  input  logic [ADDR_WIDTH-1:0]              wb_rd,
  input  logic [DATA_WIDTH-1:0]              wb_data,
  output logic [count_width(ADDR_WIDTH)-1:0] busy_count,
  output logic                               wb_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZA = ADDR_WIDTH'(ZERO_ADDR);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic                  fwd1, fwd2;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == ZA);
  endfunction

  regfile_scoreboard_bits #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_bits (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .pending     (pending),
    .issue_stall (issue_stall),
    .busy_count  (busy_count),
    .wb_error    (wb_error)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (wb_valid && !is_zero(wb_rd)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Forwarded data also counts as ready: the producer completes this cycle.
  always_comb begin
    fwd1 = (BYPASS != 0) && wb_valid && (wb_rd == rs) && !is_zero(rs);
    fwd2 = (BYPASS != 0) && wb_valid && (wb_rd == rt) && !is_zero(rt);
    output1 = is_zero(rs) ? '0 : regs[rs];
    output2 = is_zero(rt) ? '0 : regs[rt];
    if (fwd1) output1 = wb_data;
    if (fwd2) output2 = wb_data;
    output1_ready = is_zero(rs) || !pending[rs] || fwd1;
    output2_ready = is_zero(rt) || !pending[rt] || fwd2;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: default 16x16 instance for directed hazard tests and a
// 32-bit/32-entry instance for the full-occupancy sweep.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n;
  int          total = 0;
  int          bad   = 0;

  // default instance
  logic [3:0]  rs, rt, issue_rd, wb_rd;
  logic [15:0] output1, output2, wb_data;
  logic        output1_ready, output2_ready, issue_valid, issue_stall, wb_valid, wb_error;
  logic [4:0]  busy_count;

  // wide instance
  logic [4:0]  b_rs, b_rt, b_issue_rd, b_wb_rd;
  logic [31:0] b_output1, b_output2, b_wb_data;
  logic        b_output1_ready, b_output2_ready, b_issue_valid, b_issue_stall, b_wb_valid, b_wb_error;
  logic [5:0]  b_busy_count;

  typedef struct { logic [4:0] addr; logic [31:0] data; } exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  regfile_scoreboard dut (
    .clock(clock), .reset_n(reset_n), .rs(rs), .rt(rt),
    .output1(output1), .output2(output2),
    .output1_ready(output1_ready), .output2_ready(output2_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_count(busy_count), .wb_error(wb_error)
  );

  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut_wide (
    .clock(clock), .reset_n(reset_n), .rs(b_rs), .rt(b_rt),
    .output1(b_output1), .output2(b_output2),
    .output1_ready(b_output1_ready), .output2_ready(b_output2_ready),
    .issue_valid(b_issue_valid), .issue_rd(b_issue_rd), .issue_stall(b_issue_stall),
    .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .busy_count(b_busy_count), .wb_error(b_wb_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    exp_t        e;
    reset_n = 1'b0;
    rs = '0; rt = '0; issue_valid = 0; issue_rd = '0; wb_valid = 0; wb_rd = '0; wb_data = '0;
    b_rs = '0; b_rt = '0; b_issue_valid = 0; b_issue_rd = '0; b_wb_valid = 0; b_wb_rd = '0; b_wb_data = '0;
    step(); step();
    reset_n = 1'b1;
    step();

    // reset state
    rt = 4'd7;
    #2;
    check("rst_out1", output1, 0);
    check("rst_out2", output2, 0);
    check("rst_rdy1", output1_ready, 1);
    check("rst_rdy2", output2_ready, 1);
    check("rst_busy", busy_count, 0);
    check("rst_stall", issue_stall, 0);
    check("rst_err", wb_error, 0);

    // issue rd=3, then write back with forwarding
    step();
    issue_valid = 1; issue_rd = 4'd3;
    #2 check("iss3_stall", issue_stall, 0);
    step();
    issue_valid = 0; rs = 4'd3; rt = 4'd3;
    #2;
    check("iss3_busy", busy_count, 1);
    check("iss3_rdy1", output1_ready, 0);
    check("iss3_rdy2", output2_ready, 0);
    wb_valid = 1; wb_rd = 4'd3; wb_data = 16'h03C3;
    #1;
    check("fwd3_out1", output1, 16'h03C3);
    check("fwd3_rdy1", output1_ready, 1);
    check("fwd3_out2", output2, 16'h03C3);
    check("fwd3_rdy2", output2_ready, 1);
    step();
    wb_valid = 0;
    #2;
    check("st3_out1", output1, 16'h03C3);
    check("st3_rdy1", output1_ready, 1);
    check("st3_busy", busy_count, 0);

    // WAW on reg 4
    issue_valid = 1; issue_rd = 4'd4;
    step();
    check("waw_busy1", busy_count, 1);
    #2 check("waw_stall", issue_stall, 1);
    step();
    check("waw_busy_hold", busy_count, 1);
    wb_valid = 1; wb_rd = 4'd4; wb_data = 16'h4444;
    #2 check("waw_wb_nostall", issue_stall, 0);
    step();
    issue_valid = 0; wb_valid = 0; rs = 4'd4;
    #2;
    check("waw_data", output1, 16'h4444);
    check("waw_rdy", output1_ready, 0);
    check("waw_busy2", busy_count, 1);
    wb_valid = 1; wb_rd = 4'd4; wb_data = 16'h4445;
    step();
    wb_valid = 0;
    #2;
    check("waw_clr_busy", busy_count, 0);
    check("waw_clr_data", output1, 16'h4445);
    check("waw_err", wb_error, 0);

    // zero register
    rs = 4'd0;
    wb_valid = 1; wb_rd = 4'd0; wb_data = 16'hFFFF;
    #2;
    check("z_nofwd", output1, 0);
    check("z_rdy", output1_ready, 1);
    step();
    wb_valid = 0;
    #2 check("z_store", output1, 0);
    issue_valid = 1; issue_rd = 4'd0;
    #1 check("z_nostall", issue_stall, 0);
    step();
    issue_valid = 0;
    #2;
    check("z_busy", busy_count, 0);
    check("z_err", wb_error, 0);
    check("z_rdy2", output1_ready, 1);

    // spurious write-back
    wb_valid = 1; wb_rd = 4'd5; wb_data = 16'h5A5A; rs = 4'd5;
    step();
    wb_valid = 0;
    #2;
    check("sp_err", wb_error, 1);
    check("sp_data", output1, 16'h5A5A);
    issue_valid = 1; issue_rd = 4'd6;
    step();
    issue_valid = 0; wb_valid = 1; wb_rd = 4'd6; wb_data = 16'h0006;
    step();
    wb_valid = 0; issue_valid = 1; issue_rd = 4'd7;
    step();
    issue_valid = 0;
    #2;
    check("sp_err_hold", wb_error, 1);
    check("mid_busy", busy_count, 1);

    // asynchronous mid-operation reset
    reset_n = 1'b0;
    #1;
    check("ar_err", wb_error, 0);
    check("ar_busy", busy_count, 0);
    check("ar_out1", output1, 0);
    rs = 4'd7;
    #1 check("ar_rdy7", output1_ready, 1);
    step();
    reset_n = 1'b1;
    step();

    // wide sweep: fill all 31 nonzero registers
    for (int r = 1; r < 32; r++) begin
      b_issue_valid = 1; b_issue_rd = 5'(r);
      #1 check("sw_nostall", b_issue_stall, 0);
      step();
    end
    b_issue_valid = 0; b_rs = 5'd17;
    #2;
    check("sw_busy_full", b_busy_count, 31);
    check("sw_rdy17", b_output1_ready, 0);
    for (int r = 31; r >= 1; r--) begin
      d = $urandom;
      b_wb_valid = 1; b_wb_rd = 5'(r); b_wb_data = d;
      e.addr = 5'(r); e.data = d;
      exp_q.push_back(e);
      step();
    end
    b_wb_valid = 0;
    #2;
    check("sw_busy_empty", b_busy_count, 0);
    check("sw_err", b_wb_error, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      b_rs = e.addr; b_rt = e.addr;
      #1;
      check("sw_out1", b_output1, e.data);
      check("sw_out2", b_output2, e.data);
      check("sw_rdy", b_output1_ready, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
